pla_bw_capture_fifo: RTL and testbench
======================================

PLA_BW_CAPTURE_FIFO -- requirements
Module: pla_bw_capture_fifo

Interface
REQ-001 Parameter: DEPTH, default 4, FIFO entry count; SHALL be a power of two, 2..16.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset, sampled on the rising clk edge.
REQ-004 in_valid  input  1  upstream presents a code/result pair this cycle.
REQ-005 in_ready  output  1  block can accept a pair this cycle.
REQ-006 x0..x4  input  1 each  5-bit input code applied to the bw PLA stage.
REQ-007 z00..z27  input  1 each  28 PLA result bits for that code.
REQ-008 out_valid  output  1  head entry is available downstream.
REQ-009 out_ready  input  1  downstream accepts the head entry this cycle.
REQ-010 out_code  output  5  head code, {x4,x3,x2,x1,x0}.
REQ-011 out_word  output  28  head result; out_word[i] = captured z(i).
REQ-012 out_parity  output  1  XOR of all 28 out_word bits.
REQ-013 out_ones  output  5  population count of out_word, 0..28.
REQ-014 level  output  clog2(DEPTH)+1  number of occupied entries.
REQ-015 count  output  16  number of pairs accepted since reset.

Function
REQ-016 Push SHALL occur on a clk edge where in_valid=1 and in_ready=1; it stores {x4..x0, z27..z00} at the tail.
REQ-017 Pop SHALL occur on a clk edge where out_valid=1 and out_ready=1; it discards the head.
REQ-018 in_ready SHALL be 1 iff rst_n=1 and level<DEPTH; it SHALL NOT depend on out_ready in the same cycle (no pass-through when full).
REQ-019 out_valid SHALL be 1 iff level>0.
REQ-020 Operation SHALL be first-word fall-through: a pushed entry becomes visible on out_* in the cycle after the push edge, so latency is 1 cycle.
REQ-021 While out_valid=1 and out_ready=0, out_code, out_word, out_parity and out_ones SHALL hold stable.
REQ-022 When level=0, out_code, out_word, out_parity and out_ones SHALL all be 0.
REQ-023 Simultaneous push and pop with 0<level<DEPTH SHALL leave level unchanged and advance both pointers.
REQ-024 A push into an empty FIFO while out_ready=1 SHALL NOT pop in the same cycle.
REQ-025 When full, in_valid SHALL be ignored, including in cycles where a pop occurs.
REQ-026 Read and write pointers SHALL wrap modulo DEPTH, with no loss or reordering across the wrap.
REQ-027 out_parity and out_ones SHALL be combinational functions of the head entry.
REQ-028 count SHALL increment by 1 per push and saturate at 65535.
REQ-029 Entries SHALL leave in strict arrival order, and every pushed entry SHALL be popped exactly once.

Reset
REQ-030 When rst_n=0 at a clk edge, level SHALL become 0, pointers SHALL become 0 and count SHALL become 0.
REQ-031 While rst_n=0, in_ready=0 and out_valid=0, and data outputs SHALL be 0.
REQ-032 Reset asserted mid-operation SHALL discard all stored entries.
REQ-033 No push or pop SHALL occur on a reset edge.
REQ-034 Storage array contents need not be reset; outputs SHALL be gated per REQ-022.

Verification
REQ-035 Bench SHALL cover a single push/pop: push code 5'b00000 with word 28'h8000001, out_ready=1 -> next cycle out_valid=1, out_code=0, out_word=28'h8000001, out_parity=0, out_ones=2, then empty.
REQ-036 Bench SHALL cover fill: with DEPTH=4 and out_ready=0, push 5 pairs -> in_ready=0 after the 4th, level=4, count=4, and the 5th pair is not stored.
REQ-037 Bench SHALL cover full with simultaneous pop: with level=4, in_valid=1 and out_ready=1 -> one pop and no push, level=3; the next cycle both occur and level stays 3.
REQ-038 Bench SHALL cover wrap: stream codes 0..31 with random out_ready stalls -> out_code sequence is 0..31 in order, out_word equals each driven word, and out_word is stable during stalls.
REQ-039 Bench SHALL cover reset mid-stream: rst_n=0 for 1 cycle with level=3 -> level=0, out_valid=0, count=0, and the first output after reset is the first post-reset push.
REQ-040 Bench SHALL cover saturation: force 65537 pushes -> count=65535.

Source files
------------

// File: rtl/pla_bw_capture_fifo_if.sv
// Handshake bundle for the bw PLA capture FIFO: upstream code/result pairs in,
// annotated head entry out, plus occupancy and lifetime push count.
interface pla_bw_capture_fifo_if #(
    parameter int DEPTH = 4
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic          in_valid;
    logic          in_ready;
    logic          x0, x1, x2, x3, x4;
    logic          z00, z01, z02, z03, z04, z05, z06, z07, z08, z09;
    logic          z10, z11, z12, z13, z14, z15, z16, z17, z18, z19;
    logic          z20, z21, z22, z23, z24, z25, z26, z27;
    logic          out_valid;
    logic          out_ready;
    logic [4:0]    out_code;
    logic [27:0]   out_word;
    logic          out_parity;
    logic [4:0]    out_ones;
    logic [LW-1:0] level;
    logic [15:0]   count;

    modport master (
        output in_valid,
        output x0, x1, x2, x3, x4,
        output z00, z01, z02, z03, z04, z05, z06, z07, z08, z09,
        output z10, z11, z12, z13, z14, z15, z16, z17, z18, z19,
        output z20, z21, z22, z23, z24, z25, z26, z27,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_code,
        input  out_word,
        input  out_parity,
        input  out_ones,
        input  level,
        input  count
    );

    modport slave (
        input  in_valid,
        input  x0, x1, x2, x3, x4,
        input  z00, z01, z02, z03, z04, z05, z06, z07, z08, z09,
        input  z10, z11, z12, z13, z14, z15, z16, z17, z18, z19,
        input  z20, z21, z22, z23, z24, z25, z26, z27,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_code,
        output out_word,
        output out_parity,
        output out_ones,
        output level,
        output count
    );
endinterface

// File: rtl/pla_bw_capture_fifo.sv
// First-word fall-through FIFO capturing bw PLA code/result pairs, with the
// head entry annotated by its parity and population count.
module pla_bw_capture_fifo #(
    parameter int DEPTH = 4
) (
    input logic                  clk,
    input logic                  rst_n,
    pla_bw_capture_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    logic [32:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] lvl;
    logic [15:0]   pushes;
    logic [4:0]    in_code;
    logic [27:0]   in_word;
    logic [32:0]   head;
    logic [4:0]    ones;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;

    assign in_code = {bus.x4, bus.x3, bus.x2, bus.x1, bus.x0};
    assign in_word = {bus.z27, bus.z26, bus.z25, bus.z24, bus.z23, bus.z22, bus.z21,
                      bus.z20, bus.z19, bus.z18, bus.z17, bus.z16, bus.z15, bus.z14,
                      bus.z13, bus.z12, bus.z11, bus.z10, bus.z09, bus.z08, bus.z07,
                      bus.z06, bus.z05, bus.z04, bus.z03, bus.z02, bus.z01, bus.z00};

    // Readiness looks only at occupancy, so a full FIFO never admits a pair
    // even while the head is leaving.
    assign full          = (lvl == FULL_LEVEL);
    assign empty         = (lvl == '0);
    assign bus.in_ready  = rst_n & ~full;
    assign bus.out_valid = rst_n & ~empty;
    assign push          = bus.in_valid & bus.in_ready;
    assign pop           = bus.out_valid & bus.out_ready;

    // Storage carries no reset; stale contents are hidden by the output gate.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_code, in_word};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            lvl    <= '0;
            pushes <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   lvl <= lvl + LW'(1);
                2'b01:   lvl <= lvl - LW'(1);
                default: lvl <= lvl;
            endcase
            if (push && (pushes != 16'hFFFF)) begin
                pushes <= pushes + 16'd1;
            end
        end
    end

    assign head = bus.out_valid ? mem[rd_ptr] : '0;

    always_comb begin
        ones = '0;
        for (int i = 0; i < 28; i++) begin
            ones = ones + {4'd0, head[i]};
        end
    end

    assign bus.out_code   = head[32:28];
    assign bus.out_word   = head[27:0];
    assign bus.out_parity = ^head[27:0];
    assign bus.out_ones   = ones;
    assign bus.level      = lvl;
    assign bus.count      = pushes;
endmodule

// File: tb/tb_pla_bw_capture_fifo.sv
// Scoreboard bench for pla_bw_capture_fifo: directed vectors feed a queue of
// expected entries which a negedge monitor drains against every pop.
module tb_pla_bw_capture_fifo;
    localparam int DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic [4:0]  drv_code;
    logic [27:0] drv_word;
    logic [32:0] sb [$];
    int          total;
    int          bad;

    pla_bw_capture_fifo_if #(.DEPTH(DEPTH)) bus ();

    pla_bw_capture_fifo #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic driveBits(input logic [4:0] code, input logic [27:0] word);
        drv_code = code;
        drv_word = word;
        bus.x0 = code[0]; bus.x1 = code[1]; bus.x2 = code[2]; bus.x3 = code[3]; bus.x4 = code[4];
        bus.z00 = word[0];  bus.z01 = word[1];  bus.z02 = word[2];  bus.z03 = word[3];
        bus.z04 = word[4];  bus.z05 = word[5];  bus.z06 = word[6];  bus.z07 = word[7];
        bus.z08 = word[8];  bus.z09 = word[9];  bus.z10 = word[10]; bus.z11 = word[11];
        bus.z12 = word[12]; bus.z13 = word[13]; bus.z14 = word[14]; bus.z15 = word[15];
        bus.z16 = word[16]; bus.z17 = word[17]; bus.z18 = word[18]; bus.z19 = word[19];
        bus.z20 = word[20]; bus.z21 = word[21]; bus.z22 = word[22]; bus.z23 = word[23];
        bus.z24 = word[24]; bus.z25 = word[25]; bus.z26 = word[26]; bus.z27 = word[27];
    endtask

    task automatic applyStimulus(input logic valid, input logic [4:0] code, input logic [27:0] word, input logic ordy);
        bus.in_valid  = valid;
        bus.out_ready = ordy;
        driveBits(code, word);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: samples on the falling edge, i.e. the values the next rising edge acts on.
    initial begin
        logic        prev_stall;
        logic [32:0] prev_head;
        logic [32:0] exp_e;
        prev_stall = 1'b0;
        prev_head  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sb.delete();
                prev_stall = 1'b0;
                checkOutput("reset_outputs",
                            64'({bus.in_ready, bus.out_valid, bus.out_code, bus.out_word, bus.out_parity, bus.out_ones}),
                            64'(0));
            end else begin
                if (prev_stall) begin
                    checkOutput("stall_hold", 64'({bus.out_code, bus.out_word}), 64'(prev_head));
                end
                if (!bus.out_valid) begin
                    checkOutput("empty_zero",
                                64'({bus.out_code, bus.out_word, bus.out_parity, bus.out_ones}), 64'(0));
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (sb.size() == 0) begin
                        checkOutput("unexpected_pop", 64'({bus.out_code, bus.out_word}), 64'(0) - 64'(1));
                    end else begin
                        exp_e = sb.pop_front();
                        checkOutput("pop_code",   64'(bus.out_code),   64'(exp_e[32:28]));
                        checkOutput("pop_word",   64'(bus.out_word),   64'(exp_e[27:0]));
                        checkOutput("pop_parity", 64'(bus.out_parity), 64'(^exp_e[27:0]));
                        checkOutput("pop_ones",   64'(bus.out_ones),   64'($countones(exp_e[27:0])));
                    end
                end
                if (bus.in_valid && bus.in_ready) begin
                    sb.push_back({drv_code, drv_word});
                end
                prev_stall = bus.out_valid && !bus.out_ready;
                prev_head  = {bus.out_code, bus.out_word};
            end
        end
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int guard;
        logic done;
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        applyStimulus(1'b0, 5'd0, 28'd0, 1'b0);
        tick();
        tick();
        checkOutput("rst_level", 64'(bus.level), 64'(0));
        checkOutput("rst_count", 64'(bus.count), 64'(0));
        checkOutput("rst_in_ready", 64'(bus.in_ready), 64'(0));
        rst_n = 1'b1;
        #1;
        checkOutput("idle_in_ready", 64'(bus.in_ready), 64'(1));
        checkOutput("idle_out_valid", 64'(bus.out_valid), 64'(0));

        // single push then pop
        applyStimulus(1'b1, 5'd0, 28'h8000001, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        #1;
        checkOutput("single_valid", 64'(bus.out_valid), 64'(1));
        checkOutput("single_code", 64'(bus.out_code), 64'(0));
        checkOutput("single_word", 64'(bus.out_word), 64'h8000001);
        checkOutput("single_parity", 64'(bus.out_parity), 64'(0));
        checkOutput("single_ones", 64'(bus.out_ones), 64'(2));
        tick();
        checkOutput("single_empty", 64'(bus.out_valid), 64'(0));
        checkOutput("single_level", 64'(bus.level), 64'(0));
        checkOutput("single_count", 64'(bus.count), 64'(1));

        // fill from a fresh reset; the fifth pair must bounce
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        applyStimulus(1'b1, 5'd1, 28'h0000007, 1'b0); tick();
        applyStimulus(1'b1, 5'd2, 28'h1234567, 1'b0); tick();
        applyStimulus(1'b1, 5'd3, 28'hFFFFFFF, 1'b0); tick();
        applyStimulus(1'b1, 5'd4, 28'hAAAAAAA, 1'b0); tick();
        checkOutput("fill_in_ready", 64'(bus.in_ready), 64'(0));
        checkOutput("fill_level4", 64'(bus.level), 64'(4));
        applyStimulus(1'b1, 5'd5, 28'h5555555, 1'b0); tick();
        checkOutput("fill_level_after5", 64'(bus.level), 64'(4));
        checkOutput("fill_count", 64'(bus.count), 64'(4));
        checkOutput("fill_head_code", 64'(bus.out_code), 64'(1));
        checkOutput("fill_head_parity", 64'(bus.out_parity), 64'(1));
        checkOutput("fill_head_ones", 64'(bus.out_ones), 64'(3));

        // full with pop: no push this edge, both on the next
        applyStimulus(1'b1, 5'd6, 28'h00000F0, 1'b1); tick();
        checkOutput("fullpop_level", 64'(bus.level), 64'(3));
        checkOutput("fullpop_head", 64'(bus.out_code), 64'(2));
        tick();
        checkOutput("both_level", 64'(bus.level), 64'(3));
        checkOutput("both_head", 64'(bus.out_code), 64'(3));
        checkOutput("both_count", 64'(bus.count), 64'(5));
        applyStimulus(1'b0, 5'd0, 28'd0, 1'b1);
        tick(); tick(); tick();
        checkOutput("drain_level", 64'(bus.level), 64'(0));

        // stream codes 0..31 across pointer wraps with random stalls
        for (int k = 0; k < 32; k++) begin
            bus.in_valid = 1'b1;
            driveBits(k[4:0], {3'b101, k[4:0], 20'(k * 37 + 5)});
            done  = 1'b0;
            guard = 0;
            while (!done) begin
                bus.out_ready = 1'($urandom_range(0, 1));
                @(negedge clk);
                done = bus.in_ready;
                tick();
                guard++;
                if (!done && guard > 64) begin
                    checkOutput("wrap_push_timeout", 64'(bus.in_ready), 64'(1));
                    done = 1'b1;
                end
            end
        end
        applyStimulus(1'b0, 5'd0, 28'd0, 1'b1);
        guard = 0;
        while (bus.level != 0 && guard < 64) begin
            tick();
            guard++;
        end
        checkOutput("wrap_drained", 64'(bus.level), 64'(0));
        checkOutput("wrap_count", 64'(bus.count), 64'(37));

        // reset in the middle of a stream
        applyStimulus(1'b1, 5'd10, 28'h0000A0A, 1'b0); tick();
        applyStimulus(1'b1, 5'd11, 28'h0000B0B, 1'b0); tick();
        applyStimulus(1'b1, 5'd12, 28'h0000C0C, 1'b0); tick();
        checkOutput("mid_level3", 64'(bus.level), 64'(3));
        rst_n = 1'b0;
        applyStimulus(1'b1, 5'd13, 28'h0000D0D, 1'b1);
        tick();
        rst_n = 1'b1;
        bus.in_valid = 1'b0;
        #1;
        checkOutput("mid_rst_level", 64'(bus.level), 64'(0));
        checkOutput("mid_rst_count", 64'(bus.count), 64'(0));
        checkOutput("mid_rst_valid", 64'(bus.out_valid), 64'(0));
        applyStimulus(1'b1, 5'd20, 28'h7654321, 1'b1); tick();
        bus.in_valid = 1'b0;
        #1;
        checkOutput("post_rst_code", 64'(bus.out_code), 64'(20));
        checkOutput("post_rst_word", 64'(bus.out_word), 64'h7654321);
        tick();
        checkOutput("post_rst_empty", 64'(bus.level), 64'(0));

        // count saturation
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 1; i <= 65537; i++) begin
            applyStimulus(1'b1, 5'(i), 28'(i * 3), 1'b1);
            tick();
            if (i == 65534) checkOutput("sat_count_65534", 64'(bus.count), 64'(65534));
            if (i == 65535) checkOutput("sat_count_65535", 64'(bus.count), 64'(65535));
        end
        checkOutput("sat_count_final", 64'(bus.count), 64'(65535));
        applyStimulus(1'b0, 5'd0, 28'd0, 1'b1);
        tick(); tick(); tick();
        checkOutput("final_level", 64'(bus.level), 64'(0));
        checkOutput("final_sb_empty", 64'(sb.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
